multiword_add_seq: RTL and testbench

Multi-cycle sequencer that adds two 4*WORDS-bit operands using one shared external 4-bit ripple-carry adder. It feeds the adder one nibble per cycle, least significant first, and carries between cycles through a registered carry. Operands arrive through a valid/ready input handshake; the result leaves through a valid/ready output handshake. The block sits between an operand producer and the 4-bit adder datapath and owns all of that adder's inputs.

---
 rtl/multiword_add_seq.sv | 105 ++++++++++
 tb/tb_multiword_add_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_seq.sv
// rtl/multiword_add_seq.sv - nibble-serial multiword adder sequencer driving a shared external 4-bit adder
module multiword_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*WORDS-1:0]   a,
    input  logic [4*WORDS-1:0]   b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*WORDS-1:0]   sum,
    output logic                 cout,
    output logic                 busy,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_out,
    input  logic                 add_carry
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [IW-1:0]      idx;
    logic               carry_reg;
    logic [4*WORDS-1:0] a_reg;
    logic [4*WORDS-1:0] b_reg;

    // Handshake and status flags are pure decodes of the state register
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Steer the current nibble and running carry to the external adder; idle the adder otherwise
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_cin = carry_reg;
            for (int k = 0; k < WORDS; k++) begin
                if (idx == IW'(k)) begin
                    add_a = a_reg[4*k +: 4];
                    add_b = b_reg[4*k +: 4];
                end
            end
        end
    end

    // Sequencer: accept operands, walk nibbles LSB first, hold the result until it is taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (idx == IW'(k)) begin
                            sum[4*k +: 4] <= add_out;
                        end
                    end
                    carry_reg <= add_carry;
                    // The last nibble does not advance idx so it never wraps within an operation
                    if (idx == IW'(WORDS-1)) begin
                        cout  <= add_carry;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// tb/tb_multiword_add_seq.sv - randomized and directed self-checking bench for multiword_add_seq
module tb_multiword_add_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid4 = 1'b0, in_ready4, cin4 = 1'b0, out_valid4, out_ready4 = 1'b0;
    logic [15:0] a4 = '0, b4 = '0, sum4;
    logic        cout4, busy4, add_cin4, add_carry4;
    logic [3:0]  add_a4, add_b4, add_out4;

    logic        in_valid1 = 1'b0, in_ready1, cin1 = 1'b0, out_valid1, out_ready1 = 1'b0;
    logic [3:0]  a1 = '0, b1 = '0, sum1;
    logic        cout1, busy1, add_cin1, add_carry1;
    logic [3:0]  add_a1, add_b1, add_out1;

    int          total = 0;
    int          bad = 0;
    logic [15:0] last_seq;
    logic [3:0]  last_cseq;

    always #5 clk = ~clk;

    assign {add_carry4, add_out4} = {1'b0, add_a4} + {1'b0, add_b4} + {4'b0, add_cin4};
    assign {add_carry1, add_out1} = {1'b0, add_a1} + {1'b0, add_b1} + {4'b0, add_cin1};

    multiword_add_seq #(.WORDS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .busy(busy4), .add_a(add_a4), .add_b(add_b4),
        .add_cin(add_cin4), .add_out(add_out4), .add_carry(add_carry4)
    );

    multiword_add_seq #(.WORDS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1), .add_a(add_a1), .add_b(add_b1),
        .add_cin(add_cin1), .add_out(add_out1), .add_carry(add_carry1)
    );

    function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {16'b0, c};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv, input logic cv);
        int          n;
        logic [16:0] r;
        n = 0;
        while (!in_ready4 && n < 50) begin tick(); n++; end
        check({tag, "_ready"}, in_ready4, 1);
        a4 = av; b4 = bv; cin4 = cv; in_valid4 = 1'b1; out_ready4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        n = 0; last_seq = '0; last_cseq = '0;
        while (!out_valid4 && n < 20) begin
            last_seq  = {last_seq[11:0], add_a4};
            last_cseq = {last_cseq[2:0], add_cin4};
            tick();
            n++;
        end
        r = ref_add(av, bv, cv);
        check({tag, "_lat"}, n, 4);
        check({tag, "_sum"}, sum4, r[15:0]);
        check({tag, "_cout"}, cout4, r[16]);
        tick();
    endtask

    initial begin
        int          n;
        int          cyc;
        int          nres;
        int          acc[$];
        logic [16:0] expq[$];
        logic [16:0] e;
        logic        accepted;
        logic        seen;

        rst_n = 1'b0;
        tick(); tick();
        check("rst_in_ready", in_ready4, 1);
        check("rst_out_valid", out_valid4, 0);
        check("rst_busy", busy4, 0);
        check("rst_sum", sum4, 0);
        check("rst_cout", cout4, 0);
        check("rst_add", {add_a4, add_b4, add_cin4}, 0);
        rst_n = 1'b1;
        tick();

        run_op("basic", 16'h1234, 16'h4321, 1'b0);
        check("basic_add_a_seq", last_seq, 16'h4321);

        run_op("ripple", 16'hFFFF, 16'h0000, 1'b1);
        check("ripple_cin_seq", last_cseq, 4'hF);

        // Backpressure: result must hold while out_ready is low, new operands ignored
        a4 = 16'h1111; b4 = 16'h2222; cin4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b0;
        tick();
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 20) begin tick(); n++; end
        check("bp_lat", n, 4);
        a4 = 16'hAAAA; b4 = 16'h5555; cin4 = 1'b1; in_valid4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", out_valid4, 1);
            check("bp_in_ready", in_ready4, 0);
            check("bp_sum", sum4, 16'h3333);
            check("bp_cout", cout4, 0);
        end
        out_ready4 = 1'b1;
        tick();
        check("bp_idle_ready", in_ready4, 1);
        check("bp_idle_valid", out_valid4, 0);
        tick();
        in_valid4 = 1'b0;
        check("bp_accept_busy", busy4, 1);
        n = 0;
        while (!out_valid4 && n < 20) begin tick(); n++; end
        e = ref_add(16'hAAAA, 16'h5555, 1'b1);
        check("bp_new_sum", sum4, e[15:0]);
        check("bp_new_cout", cout4, e[16]);
        tick();

        // Reset in the middle of an operation
        a4 = 16'h1234; b4 = 16'h1111; cin4 = 1'b0; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_in_ready", in_ready4, 1);
        check("mid_rst_out_valid", out_valid4, 0);
        check("mid_rst_busy", busy4, 0);
        check("mid_rst_sum", sum4, 0);
        check("mid_rst_cout", cout4, 0);
        check("mid_rst_add", {add_a4, add_b4, add_cin4}, 0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); seen = seen | out_valid4; end
        check("mid_rst_no_result", seen, 0);

        // Back-to-back with in_valid and out_ready held high
        a4 = 16'h00FF; b4 = 16'h0001; cin4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b1;
        expq.push_back(ref_add(16'h00FF, 16'h0001, 1'b0));
        cyc = 0; nres = 0;
        while (nres < 2 && cyc < 40) begin
            accepted = in_valid4 && in_ready4;
            tick();
            cyc++;
            if (accepted) begin
                acc.push_back(cyc);
                if (acc.size() == 1) begin
                    a4 = 16'h8000; b4 = 16'h8000;
                    expq.push_back(ref_add(16'h8000, 16'h8000, 1'b0));
                end
            end
            if (out_valid4) begin
                e = (expq.size() > 0) ? expq.pop_front() : 17'h1FFFF;
                check("b2b_sum", sum4, e[15:0]);
                check("b2b_cout", cout4, e[16]);
                nres++;
            end
        end
        in_valid4 = 1'b0;
        check("b2b_results", nres, 2);
        check("b2b_gap", (acc.size() >= 2) ? (acc[1] - acc[0]) : 0, 6);
        tick(); tick();

        // Randomized operands against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        // Single-nibble configuration
        a1 = 4'hF; b1 = 4'h1; cin1 = 1'b0; in_valid1 = 1'b1; out_ready1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 20) begin tick(); n++; end
        check("w1_lat", n, 1);
        check("w1_sum", sum1, 4'h0);
        check("w1_cout", cout1, 1);
        tick();
        check("w1_idle", in_ready1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
